// File: rtl/seg7_pkg.sv
// Shared constants, FSM state and pattern decode for the 7-segment reader.
// Segment order in a pattern is [6:0] = top, upper-right, lower-right, bottom, lower-left, upper-left, middle.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_SETTLE,
        ST_LOCKED
    } state_e;

    // CLS_NONE only marks "nothing accepted yet"; decode never returns it.
    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_DIGIT,
        CLS_BLANK,
        CLS_ERR
    } seg_class_e;

    typedef struct packed {
        seg_class_e cls;
        logic [3:0] digit;
    } seg_dec_t;

    function automatic seg_dec_t seg7_decode_fn(input logic [6:0] pat);
        seg_dec_t r;
        r.cls   = CLS_DIGIT;
        r.digit = 4'd0;
        case (pat)
            SEG_0:     r.digit = 4'd0;
            SEG_1:     r.digit = 4'd1;
            SEG_2:     r.digit = 4'd2;
            SEG_3:     r.digit = 4'd3;
            SEG_4:     r.digit = 4'd4;
            SEG_5:     r.digit = 4'd5;
            SEG_6:     r.digit = 4'd6;
            SEG_7:     r.digit = 4'd7;
            SEG_8:     r.digit = 4'd8;
            SEG_9:     r.digit = 4'd9;
            SEG_BLANK: r.cls   = CLS_BLANK;
            default:   r.cls   = CLS_ERR;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] next_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern classifier: one-hot {digit_valid, blank, pattern_err}
// plus the decoded digit (0 unless the pattern is a legal digit).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       blank,
    output logic       pattern_err
);

    seg_dec_t dec;

    assign dec         = seg7_decode_fn(pattern);
    assign digit       = dec.digit;
    assign digit_valid = (dec.cls == CLS_DIGIT);
    assign blank       = (dec.cls == CLS_BLANK);
    assign pattern_err = (dec.cls == CLS_ERR);

endmodule

// File: rtl/seg7_reader.sv
// Samples a 7-segment bus, debounces it over STABLE_CYCLES, decodes it and flags
// illegal patterns and out-of-sequence steps. Define SEG7_PERIOD_MEASURE_EN to measure digit period.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           segments_in,
    output logic [3:0]           digit,
    output logic                 digit_valid,
    output logic                 blank,
    output logic                 pattern_err,
    output logic                 new_digit,
    output logic                 seq_error,
    output logic [CNT_WIDTH-1:0] period
);

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    logic [6:0]    sync1, sample;
    logic [6:0]    candidate;
    logic [SW-1:0] stab_cnt;
    state_e        state;
    seg_class_e    prev_class;
    logic          have_digit;

    logic [3:0]    dec_digit;
    logic          dec_valid, dec_blank, dec_err;
    logic          accept, fire_new, fire_seq;

    // segments_in may be asynchronous to clk
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sample <= '0;
        end else begin
            sync1  <= segments_in;
            sample <= sync1;
        end
    end

    // Candidate equals sample whenever acceptance fires, so decode the candidate.
    seg7_decode u_decode (
        .pattern     (candidate),
        .digit       (dec_digit),
        .digit_valid (dec_valid),
        .blank       (dec_blank),
        .pattern_err (dec_err)
    );

    always_comb begin
        accept   = (state == ST_SETTLE) && (sample == candidate) &&
                   (stab_cnt == SW'(STABLE_CYCLES - 1));
        fire_new = accept && dec_valid && (!have_digit || dec_digit != digit);
        fire_seq = fire_new && (prev_class == CLS_DIGIT) &&
                   (dec_digit != next_digit(digit));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_EMPTY;
            candidate   <= '0;
            stab_cnt    <= '0;
            prev_class  <= CLS_NONE;
            have_digit  <= 1'b0;
            digit       <= '0;
            digit_valid <= 1'b0;
            blank       <= 1'b0;
            pattern_err <= 1'b0;
            new_digit   <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            new_digit <= 1'b0;
            seq_error <= 1'b0;
            if (sample != candidate) begin
                candidate <= sample;
                stab_cnt  <= '0;
                state     <= ST_SETTLE;
            end else if (state == ST_SETTLE) begin
                if (accept) begin
                    state       <= ST_LOCKED;
                    digit_valid <= dec_valid;
                    blank       <= dec_blank;
                    pattern_err <= dec_err;
                    new_digit   <= fire_new;
                    seq_error   <= fire_seq;
                    if (dec_valid) begin
                        digit      <= dec_digit;
                        have_digit <= 1'b1;
                        prev_class <= CLS_DIGIT;
                    end else begin
                        prev_class <= dec_blank ? CLS_BLANK : CLS_ERR;
                    end
                end else begin
                    stab_cnt <= stab_cnt + SW'(1);
                end
            end
        end
    end

`ifdef SEG7_PERIOD_MEASURE_EN
    logic [CNT_WIDTH-1:0] free_cnt, period_q;

    // Restart at 1 on the pulse edge so the next pulse reads the exact cycle distance.
    always_ff @(posedge clk) begin
        if (reset) begin
            free_cnt <= '0;
            period_q <= '0;
        end else if (fire_new) begin
            free_cnt <= CNT_WIDTH'(1);
            if (have_digit)
                period_q <= free_cnt;
        end else if (free_cnt != '1) begin
            free_cnt <= free_cnt + CNT_WIDTH'(1);
        end
    end

    assign period = period_q;
`else
    assign period = '0;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Directed self-checking bench for seg7_reader (STABLE_CYCLES=4, CNT_WIDTH=24).
module tb_seg7_reader;
    import seg7_pkg::*;

    logic        clk;
    logic        reset;
    logic [6:0]  segments_in;
    logic [3:0]  digit;
    logic        digit_valid, blank, pattern_err, new_digit, seq_error;
    logic [23:0] period;

    int vectors, miscompares;
    int nd_cnt, se_cnt, co_bad, hold_bad;
    bit hold_chk;
    logic [6:0] hold_exp;

    seg7_reader #(.STABLE_CYCLES(4), .CNT_WIDTH(24)) dut (
        .clk         (clk),
        .reset       (reset),
        .segments_in (segments_in),
        .digit       (digit),
        .digit_valid (digit_valid),
        .blank       (blank),
        .pattern_err (pattern_err),
        .new_digit   (new_digit),
        .seq_error   (seq_error),
        .period      (period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SEG7_PERIOD_MEASURE_EN
    localparam logic [23:0] EXP_PERIOD = 24'd100;
`else
    localparam logic [23:0] EXP_PERIOD = 24'd0;
`endif

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [6:0] pat, input int cycles);
        segments_in = pat;
        repeat (cycles) begin
            step();
            nd_cnt += int'(new_digit);
            se_cnt += int'(seq_error);
            if (seq_error && !new_digit) co_bad++;
            if (hold_chk && {digit_valid, blank, pattern_err, digit} !== hold_exp) hold_bad++;
        end
    endtask

    task automatic clr();
        nd_cnt = 0;
        se_cnt = 0;
        co_bad = 0;
        hold_bad = 0;
    endtask

    task automatic do_reset(input logic [6:0] pat);
        segments_in = pat;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        hold_chk = 1'b0;
        hold_exp = '0;
        clr();

        // 1: reset state and first-acceptance latency
        do_reset(SEG_BLANK);
        chk("rst_digit", digit, 0);
        chk("rst_flags", {digit_valid, blank, pattern_err, new_digit, seq_error}, 0);
        chk("rst_period", period, 0);
        segments_in = SEG_0;
        repeat (6) step();
        chk("t1_pre_nd", {new_digit, digit_valid}, 0);
        step();
        chk("t1_nd", new_digit, 1);
        chk("t1_out", {digit_valid, blank, pattern_err, seq_error, digit}, {4'b1000, 4'd0});
        step();
        chk("t1_pulse_end", new_digit, 0);

        // 2: 0 -> 1 .. 9 -> 0
        clr();
        for (int d = 1; d <= 10; d++) begin
            case (d % 10)
                0: run(SEG_0, 10);
                1: run(SEG_1, 10);
                2: run(SEG_2, 10);
                3: run(SEG_3, 10);
                4: run(SEG_4, 10);
                5: run(SEG_5, 10);
                6: run(SEG_6, 10);
                7: run(SEG_7, 10);
                8: run(SEG_8, 10);
                default: run(SEG_9, 10);
            endcase
        end
        chk("t2_pulses", nd_cnt, 10);
        chk("t2_seqerr", se_cnt, 0);
        chk("t2_digit", digit, 0);

        // 3: 3 -> 5 out of sequence
        do_reset(SEG_3);
        clr();
        run(SEG_3, 10);
        chk("t3_first", {nd_cnt[7:0], se_cnt[7:0]}, {8'd1, 8'd0});
        clr();
        run(SEG_5, 10);
        chk("t3_nd", nd_cnt, 1);
        chk("t3_se", se_cnt, 1);
        chk("t3_coincident", co_bad, 0);
        chk("t3_digit", digit, 5);

        // 4: glitch shorter than STABLE_CYCLES, then one just long enough
        run(SEG_4, 10);
        clr();
        hold_exp = {3'b100, 4'd4};
        hold_chk = 1'b1;
        run(SEG_8, 3);
        run(SEG_4, 12);
        hold_chk = 1'b0;
        chk("t4_glitch_hold", hold_bad, 0);
        chk("t4_glitch_pulses", nd_cnt + se_cnt, 0);
        clr();
        run(SEG_8, 5);
        run(SEG_4, 12);
        chk("t4_long_pulses", nd_cnt, 2);
        chk("t4_long_digit", digit, 4);

        // 5: illegal pattern, recovery, blank and re-accept
        clr();
        run(7'b1010101, 10);
        chk("t5_err", {digit_valid, blank, pattern_err, digit}, {3'b001, 4'd4});
        chk("t5_err_nd", nd_cnt, 0);
        run(SEG_2, 10);
        chk("t5_two_nd", nd_cnt, 1);
        chk("t5_two_se", se_cnt, 0);
        chk("t5_two_out", {digit_valid, blank, pattern_err, digit}, {3'b100, 4'd2});
        clr();
        run(SEG_BLANK, 10);
        chk("t5_blank", {digit_valid, blank, pattern_err, digit}, {3'b010, 4'd2});
        run(SEG_2, 10);
        chk("t5_reaccept_nd", nd_cnt, 0);
        chk("t5_reaccept_dv", digit_valid, 1);

        // 6: period measurement at 100-cycle spacing, then reset mid-settle
        do_reset(SEG_0);
        run(SEG_0, 100);
        chk("t6_period_first", period, 0);
        run(SEG_1, 100);
        chk("t6_period_2nd", period, EXP_PERIOD);
        run(SEG_2, 100);
        chk("t6_period_3rd", period, EXP_PERIOD);
        segments_in = SEG_7;
        repeat (4) step();
        reset = 1'b1;
        step();
        chk("t6_mid_rst", {digit_valid, blank, pattern_err, new_digit, seq_error, digit}, 0);
        chk("t6_mid_rst_period", period, 0);
        reset = 1'b0;
        clr();
        run(SEG_7, 10);
        chk("t6_after_rst", {nd_cnt[3:0], se_cnt[3:0], digit}, {4'd1, 4'd0, 4'd7});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
